fifo_burst_reader: RTL
======================

// Module: fifo_burst_reader
// PURPOSE
//  Read-side controller for the 16-deep synchronous FIFO: drains words via the FIFO rd strobe and
//  re-emits them as a valid/ready stream framed into bursts (m_last on final beat). Sits between
//  fifo_mem outputs (data_out, fifo_empty, fifo_threshold) and a downstream packet consumer.
//  Never issues rd while fifo_empty=1, so it cannot cause fifo_underflow.
// PARAMETERS
//  DATA_W        8   width of FIFO word and stream data
//  BURST_LEN     8   max beats per burst (2..16)
//  IDLE_TIMEOUT  16  cycles FIFO must stay non-empty in IDLE before a short burst is forced (>=1)
// PORTS
//  clk             in   1       clock, all logic on posedge
//  rst_n           in   1       asynchronous reset, active-low
//  fifo_data       in   DATA_W  FIFO data_out (first-word-fall-through, valid when fifo_empty=0)
//  fifo_empty      in   1       FIFO empty flag
//  fifo_threshold  in   1       FIFO holds >= 8 words
//  fifo_rd         out  1       pop strobe to FIFO rd (combinational)
//  m_valid         out  1       stream beat valid
//  m_ready         in   1       downstream accept
//  m_data          out  DATA_W  stream data
//  m_last          out  1       final beat of burst
//  busy            out  1       state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, idle_cnt=0, pop_cnt=0, h_valid=0, m_valid=0, m_data=0, m_last=0, busy=0.
//  Storage: 1-word hold reg H (h_valid,h_data) + output reg O (m_valid,m_data,m_last).
//  FSM IDLE -> RUN -> FLUSH -> IDLE:
//   IDLE: idle_cnt clears when fifo_empty=1, else increments, saturating at IDLE_TIMEOUT.
//         Go RUN when fifo_threshold=1, or fifo_empty=0 && idle_cnt==IDLE_TIMEOUT. pop_cnt<=0.
//   RUN: pop = ~fifo_empty && pop_cnt<BURST_LEN && (~h_valid || promote). fifo_rd=pop only in RUN.
//        On pop: h_data<=fifo_data, h_valid<=1, pop_cnt++.
//        promote = h_valid && (~m_valid || m_ready): O<=H; h_valid cleared unless same-cycle pop.
//        m_last at promote = (pop_cnt==BURST_LEN) || fifo_empty (sampled that cycle); on
//        m_last=1 promote go FLUSH (no further pops). Burst thus ends early if FIFO runs dry.
//   FLUSH: no pops; on m_valid && m_ready && m_last -> IDLE, idle_cnt<=0.
//  O drains (m_valid<=0) on m_valid&&m_ready with no promote. m_data/m_last stable while m_valid&&~m_ready.
//  Latency: RUN entry cycle N pops; m_valid first high N+2. Sustained 1 beat/clk when m_ready=1.
//  Burst beats = min(BURST_LEN, words available contiguously); >=1 always.
//  Writes landing during FLUSH wait for next burst. Word order preserved exactly.
//  pop_cnt width clog2(BURST_LEN+1); idle_cnt width clog2(IDLE_TIMEOUT+1).
//  Reset mid-burst: all state cleared immediately; words held in H/O are discarded.
// CONFIGURATION
//  FIFO_READER_PARITY_EN defined: extra output m_parity (1 bit) = ^m_data (even parity bit),
//   registered with O, reset 0, same stability rule as m_data.
//  Undefined: port m_parity absent; no parity logic.
// TESTING
//  Reset: rst_n=0 mid-burst with m_ready=0 -> all outputs 0 asynchronously, fifo_rd=0.
//  Write 10 words 0x01..0x0A, m_ready=1 -> threshold start; beats 0x01..0x08, m_last on 0x08;
//   then 2 words idle IDLE_TIMEOUT cycles -> burst 0x09,0x0A, m_last on 0x0A.
//  Write 1 word 0x5A, no more -> after 16 non-empty IDLE cycles, single beat 0x5A with m_last=1.
//  16 words, m_ready toggled 1/0 each cycle -> m_data/m_last held while stalled, no drop/dup,
//   two bursts of 8, fifo_underflow never set.
//  Continuous write 1 word/clk during burst -> 8-beat bursts back-to-back, order preserved.
//  With FIFO_READER_PARITY_EN: m_data=0x07 -> m_parity=1; m_data=0x03 -> m_parity=0.

Source files
------------

// File: rtl/fifo_burst_reader.sv
// Read-side FIFO controller: pops a FWFT FIFO and re-emits words as valid/ready bursts with m_last.
// Optional even-parity output m_parity is built when FIFO_READER_PARITY_EN is defined.
module fifo_burst_reader #(
    parameter int DATA_W       = 8,
    parameter int BURST_LEN    = 8,
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              fifo_empty,
    input  logic              fifo_threshold,
    output logic              fifo_rd,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
`ifdef FIFO_READER_PARITY_EN
    output logic              m_parity,
`endif
    output logic              busy,
    output logic [1:0]        dbg_state
);

    // Stream handshake: a beat transfers on a rising clk edge where m_valid && m_ready;
    // once m_valid is high, m_data/m_last (and m_parity) hold until that transfer.

    localparam int PW = $clog2(BURST_LEN + 1);
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [PW-1:0] BL = PW'(BURST_LEN);
    localparam logic [IW-1:0] IT = IW'(IDLE_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t            r_state;
    logic [PW-1:0]     r_pop_cnt;
    logic [IW-1:0]     r_idle_cnt;
    logic              r_h_valid;
    logic [DATA_W-1:0] r_h_data;
    logic              r_m_valid;
    logic [DATA_W-1:0] r_m_data;
    logic              r_m_last;
`ifdef FIFO_READER_PARITY_EN
    logic              r_m_parity;
`endif

    logic w_promote;
    logic w_pop;
    logic w_last;
    logic w_start;

    // H moves into O whenever O is empty or being accepted this cycle.
    assign w_promote = (r_state == S_RUN) && r_h_valid && (~r_m_valid || m_ready);
    assign w_pop     = (r_state == S_RUN) && ~fifo_empty && (r_pop_cnt < BL) &&
                       (~r_h_valid || w_promote);
    // A dry FIFO at promote time closes the burst early.
    assign w_last    = (r_pop_cnt == BL) || fifo_empty;
    assign w_start   = fifo_threshold || (~fifo_empty && (r_idle_cnt == IT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pop_cnt  <= '0;
            r_idle_cnt <= '0;
            r_h_valid  <= 1'b0;
            r_h_data   <= '0;
            r_m_valid  <= 1'b0;
            r_m_data   <= '0;
            r_m_last   <= 1'b0;
`ifdef FIFO_READER_PARITY_EN
            r_m_parity <= 1'b0;
`endif
        end else begin
            if (w_pop) begin
                r_h_data  <= fifo_data;
                r_h_valid <= 1'b1;
            end else if (w_promote) begin
                r_h_valid <= 1'b0;
            end

            if (w_promote) begin
                r_m_valid  <= 1'b1;
                r_m_data   <= r_h_data;
                r_m_last   <= w_last;
`ifdef FIFO_READER_PARITY_EN
                r_m_parity <= ^r_h_data;
`endif
            end else if (r_m_valid && m_ready) begin
                r_m_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    r_pop_cnt <= '0;
                    if (fifo_empty)
                        r_idle_cnt <= '0;
                    else if (r_idle_cnt != IT)
                        r_idle_cnt <= r_idle_cnt + IW'(1);
                    if (w_start)
                        r_state <= S_RUN;
                end
                S_RUN: begin
                    if (w_pop)
                        r_pop_cnt <= r_pop_cnt + PW'(1);
                    if (w_promote && w_last)
                        r_state <= S_FLUSH;
                end
                S_FLUSH: begin
                    if (r_m_valid && m_ready && r_m_last) begin
                        r_state    <= S_IDLE;
                        r_idle_cnt <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign fifo_rd   = w_pop;
    assign m_valid   = r_m_valid;
    assign m_data    = r_m_data;
    assign m_last    = r_m_last;
`ifdef FIFO_READER_PARITY_EN
    assign m_parity  = r_m_parity;
`endif
    assign busy      = (r_state != S_IDLE);
    assign dbg_state = r_state;

endmodule
